// File: rtl/smc_pwm_cap_pkg.sv
// Shared types and register map for the SMC PWM capture block.
package smc_pwm_cap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HIGH,
    S_LOW
  } cap_state_e;

  localparam int A_CTRL   = 'h00;
  localparam int A_STATUS = 'h02;
  localparam int A_HIGH   = 'h04;
  localparam int A_PERIOD = 'h06;

  localparam int C_EN     = 0;
  localparam int C_CONT   = 1;
  localparam int C_IE     = 2;
  localparam int C_SRC_LO = 3;
  localparam int C_SRC_HI = 7;
  localparam int SRC_W    = 5;

  localparam int ST_DONE  = 0;
  localparam int ST_OVF   = 1;
  localparam int ST_BUSY  = 2;

endpackage

// File: rtl/smc_pwm_cap_engine.sv
// Synchronizer, edge detect, measurement FSM and saturating counters.
module smc_pwm_cap_engine #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             en,
  input  logic             stop,
  input  logic             cont,
  input  logic             restart,
  output logic             busy,
  output logic             cap_valid,
  output logic             cap_ovf,
  output logic             en_clr,
  output logic [CNT_W-1:0] cap_high,
  output logic [CNT_W-1:0] cap_period
);
  import smc_pwm_cap_pkg::*;

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cap_state_e       state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             prev_q, prev_d;
  logic [1:0]       ign_q, ign_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] pinc, hinc;
  logic             live, rise, fall;

  always_comb begin
    s1_d       = din;
    s2_d       = s1_q;
    prev_d     = s2_q;
    ign_d      = (ign_q != 2'd0) ? ign_q - 2'd1 : 2'd0;
    live       = (ign_q == 2'd0);
    rise       = live & s2_q & ~prev_q;
    fall       = live & ~s2_q & prev_q;
    pinc       = pcnt_q + ONE;
    hinc       = hcnt_q + ONE;
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    pcnt_d     = pcnt_q;
    cap_valid  = 1'b0;
    cap_ovf    = 1'b0;
    en_clr     = 1'b0;
    cap_high   = hcnt_q;
    cap_period = pcnt_q;
    if (!en || stop) begin
      state_d = S_IDLE;
      hcnt_d  = '0;
      pcnt_d  = '0;
    end else if (restart && state_q != S_IDLE) begin
      // Old source still sits in the sync chain for three edges.
      state_d = S_ARM;
      hcnt_d  = '0;
      pcnt_d  = '0;
      ign_d   = 2'd3;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARM;
          hcnt_d  = '0;
          pcnt_d  = '0;
        end
        S_ARM: begin
          if (rise) begin
            state_d = S_HIGH;
            hcnt_d  = ONE;
            pcnt_d  = ONE;
          end
        end
        S_HIGH: begin
          pcnt_d = pinc;
          if (fall) state_d = S_LOW;
          else hcnt_d = hinc;
        end
        S_LOW: begin
          if (rise) begin
            cap_valid = 1'b1;
            if (cont) begin
              state_d = S_HIGH;
              hcnt_d  = ONE;
              pcnt_d  = ONE;
            end else begin
              state_d = S_IDLE;
              hcnt_d  = '0;
              pcnt_d  = '0;
              en_clr  = 1'b1;
            end
          end else begin
            pcnt_d = pinc;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if ((state_q == S_HIGH || (state_q == S_LOW && !rise))
          && pinc == MAX) begin
        cap_valid  = 1'b1;
        cap_ovf    = 1'b1;
        en_clr     = 1'b1;
        cap_high   = hcnt_d;
        cap_period = MAX;
        state_d    = S_IDLE;
        hcnt_d     = '0;
        pcnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      ign_q   <= 2'd0;
      hcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      ign_q   <= ign_d;
      hcnt_q  <= hcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: rtl/smc_pwm_capture.sv
// PWM capture: register file, bus decode, coil source mux and irq.
module smc_pwm_capture
  import smc_pwm_cap_pkg::*;
#(
  parameter int NCH    = 12,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  input  logic [NCH-1:0]    mnm,
  input  logic [NCH-1:0]    mnp,
  output logic              irq
);

  logic             en_q, en_d;
  logic             cont_q, cont_d;
  logic             ie_q, ie_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [DATA_W-1:0] dataout_q, dataout_d;
  logic [DATA_W-1:0] rdata;
  logic [SRC_W-1:0] wsrc;
  logic             wr, rd, wr_ctrl, wr_stat;
  logic             rd_ctrl, rd_stat, rd_high, rd_period;
  logic             src_bit, stop, restart;
  logic             busy, cap_valid, cap_ovf, en_clr;
  logic [CNT_W-1:0] cap_high, cap_period;
  logic             unused_bits;

  assign wr        = sel & write;
  assign rd        = sel & ~write;
  assign wr_ctrl   = wr && addr == ADDR_W'(A_CTRL);
  assign wr_stat   = wr && addr == ADDR_W'(A_STATUS);
  assign rd_ctrl   = addr == ADDR_W'(A_CTRL);
  assign rd_stat   = addr == ADDR_W'(A_STATUS);
  assign rd_high   = addr == ADDR_W'(A_HIGH);
  assign rd_period = addr == ADDR_W'(A_PERIOD);
  assign wsrc      = datain[C_SRC_HI:C_SRC_LO];
  assign stop      = wr_ctrl & ~datain[C_EN];
  assign restart   = wr_ctrl & datain[C_EN] & (wsrc != src_q);
  assign unused_bits = ^datain[DATA_W-1:C_SRC_HI+1];

  always_comb begin
    src_bit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (src_q == SRC_W'(i)) src_bit = mnm[i];
      if (src_q == SRC_W'(i + NCH)) src_bit = mnp[i];
    end
  end

  smc_pwm_cap_engine #(
    .CNT_W(CNT_W)
  ) u_engine (
    .clk       (clk),
    .rst_n     (reset),
    .din       (src_bit),
    .en        (en_q),
    .stop      (stop),
    .cont      (cont_q),
    .restart   (restart),
    .busy      (busy),
    .cap_valid (cap_valid),
    .cap_ovf   (cap_ovf),
    .en_clr    (en_clr),
    .cap_high  (cap_high),
    .cap_period(cap_period)
  );

  always_comb begin
    en_d     = en_q;
    cont_d   = cont_q;
    ie_d     = ie_q;
    src_d    = src_q;
    high_d   = high_q;
    period_d = period_q;
    if (wr_ctrl) begin
      en_d   = datain[C_EN];
      cont_d = datain[C_CONT];
      ie_d   = datain[C_IE];
      src_d  = wsrc;
    end
    if (en_clr) en_d = 1'b0;
    // A capture landing with a w1c wins.
    done_d = done_q & ~(wr_stat & datain[ST_DONE]);
    ovf_d  = ovf_q & ~(wr_stat & datain[ST_OVF]);
    if (cap_valid) begin
      done_d   = 1'b1;
      high_d   = cap_high;
      period_d = cap_period;
    end
    if (cap_ovf) ovf_d = 1'b1;
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      rd_ctrl:   rdata[7:0] = {src_q, ie_q, cont_q, en_q};
      rd_stat:   rdata[2:0] = {busy, ovf_q, done_q};
      rd_high:   rdata = DATA_W'(high_q);
      rd_period: rdata = DATA_W'(period_q);
      default:   rdata = '0;
    endcase
    dataout_d = rd ? rdata : dataout_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b0;
      cont_q    <= 1'b0;
      ie_q      <= 1'b0;
      src_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      high_q    <= '0;
      period_q  <= '0;
      dataout_q <= '0;
    end else begin
      en_q      <= en_d;
      cont_q    <= cont_d;
      ie_q      <= ie_d;
      src_q     <= src_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      high_q    <= high_d;
      period_q  <= period_d;
      dataout_q <= dataout_d;
    end
  end

  assign dataout = dataout_q;
  assign irq     = done_q & ie_q;

endmodule

// File: tb/tb_smc_pwm_capture.sv
// Directed bench for smc_pwm_capture: register tables plus
// hand-timed sequences for continuous, overflow and reset cases.
`timescale 1ns/1ps
module tb_smc_pwm_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        write = 1'b0;
  logic [6:0]  addr = '0;
  logic [15:0] datain = '0;
  logic [15:0] dataout;
  logic [11:0] mnm, mnp;
  logic        irq;
  logic [23:0] drv = '0;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int pmode = 0;
  int pbit = 0;
  int pper = 100;
  int phigh = 25;
  int phase = 0;
  int c0;

  typedef struct {
    string       name;
    logic [6:0]  a;
    logic [15:0] exp;
  } rd_vec_t;

  rd_vec_t rst_tab[5];
  rd_vec_t cap_tab[4];

  assign mnm = drv[11:0];
  assign mnp = drv[23:12];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  smc_pwm_capture dut (
    .clk    (clk),
    .reset  (reset),
    .sel    (sel),
    .write  (write),
    .addr   (addr),
    .datain (datain),
    .dataout(dataout),
    .mnm    (mnm),
    .mnp    (mnp),
    .irq    (irq)
  );

  initial begin
    forever begin
      @(posedge clk);
      #1;
      drv = '0;
      if (pmode == 1) begin
        drv[pbit] = (phase < phigh);
        phase = (phase + 1 >= pper) ? 0 : phase + 1;
      end else if (pmode == 2) begin
        drv[pbit] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; write = 1'b1; addr = a; datain = d;
    @(negedge clk);
    sel = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [15:0] d);
    @(negedge clk);
    sel = 1'b1; write = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = dataout;
  endtask

  task automatic rd_chk(input string name, input logic [6:0] a,
                        input logic [15:0] exp);
    logic [15:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_irq(input int max, input string name);
    int n = 0;
    while (!irq && n < max) begin
      @(negedge clk);
      n++;
    end
    check(name, {15'd0, irq}, 16'h0001);
  endtask

  task automatic set_pwm(input int m, input int b, input int p,
                         input int h);
    pmode = m; pbit = b; pper = p; phigh = h;
    repeat (50) @(negedge clk);
  endtask

  initial begin
    rst_tab[0] = '{"rst_ctrl",   7'h00, 16'h0000};
    rst_tab[1] = '{"rst_status", 7'h02, 16'h0000};
    rst_tab[2] = '{"rst_high",   7'h04, 16'h0000};
    rst_tab[3] = '{"rst_period", 7'h06, 16'h0000};
    rst_tab[4] = '{"rst_unmap",  7'h10, 16'h0000};
    cap_tab[0] = '{"one_status", 7'h02, 16'h0001};
    cap_tab[1] = '{"one_high",   7'h04, 16'd25};
    cap_tab[2] = '{"one_period", 7'h06, 16'd100};
    cap_tab[3] = '{"one_ctrl",   7'h00, 16'h001C};

    repeat (3) @(negedge clk);
    check("rst_dataout", dataout, 16'h0000);
    check("rst_irq", {15'd0, irq}, 16'h0000);
    reset = 1'b1;
    for (int i = 0; i < 5; i++)
      rd_chk(rst_tab[i].name, rst_tab[i].a, rst_tab[i].exp);

    // single shot on mnm[3]
    set_pwm(1, 3, 100, 25);
    bus_write(7'h00, 16'h001D);
    wait_irq(500, "one_irq");
    for (int i = 0; i < 4; i++)
      rd_chk(cap_tab[i].name, cap_tab[i].a, cap_tab[i].exp);
    bus_write(7'h02, 16'h0001);
    check("one_irq_clr", {15'd0, irq}, 16'h0000);

    // continuous on mnp[0]
    set_pwm(1, 12, 40, 10);
    bus_write(7'h00, 16'h0067);
    for (int p = 0; p < 4; p++) begin
      wait_irq(300, $sformatf("cont_irq%0d", p));
      rd_chk($sformatf("cont_period%0d", p), 7'h06, 16'd40);
      if (p == 0) rd_chk("cont_high", 7'h04, 16'd10);
      bus_write(7'h02, 16'h0001);
      check($sformatf("cont_irq_clr%0d", p), {15'd0, irq}, 16'h0000);
    end
    rd_chk("cont_busy", 7'h02, 16'h0004);

    // w1c on the exact capture edge
    wait_irq(300, "edge_irq");
    c0 = cyc;
    bus_write(7'h02, 16'h0001);
    check("edge_pre_clr", {15'd0, irq}, 16'h0000);
    while (cyc < c0 + 39) @(negedge clk);
    sel = 1'b1; write = 1'b1; addr = 7'h02; datain = 16'h0003;
    @(negedge clk);
    sel = 1'b0; write = 1'b0;
    check("edge_set_wins", {15'd0, irq}, 16'h0001);
    rd_chk("edge_status", 7'h02, 16'h0005);
    rd_chk("rd_period", 7'h06, 16'd40);
    repeat (2) @(negedge clk);
    check("rd_hold", dataout, 16'd40);

    // EN cleared while in HIGH
    bus_write(7'h00, 16'h0066);
    rd_chk("stop_status", 7'h02, 16'h0001);
    rd_chk("stop_high", 7'h04, 16'd10);
    rd_chk("stop_period", 7'h06, 16'd40);
    rd_chk("stop_ctrl", 7'h00, 16'h0066);
    rd_chk("unmapped", 7'h10, 16'h0000);

    // stuck-high saturation on mnm[5]
    bus_write(7'h02, 16'h0003);
    set_pwm(0, 5, 100, 25);
    bus_write(7'h00, 16'h002D);
    repeat (5) @(negedge clk);
    pmode = 2;
    wait_irq(70000, "ovf_irq");
    rd_chk("ovf_status", 7'h02, 16'h0003);
    rd_chk("ovf_period", 7'h06, 16'hFFFF);
    rd_chk("ovf_high", 7'h04, 16'hFFFF);
    rd_chk("ovf_ctrl", 7'h00, 16'h002C);

    // async reset while in LOW
    bus_write(7'h02, 16'h0003);
    set_pwm(1, 3, 100, 25);
    bus_write(7'h00, 16'h001F);
    wait_irq(500, "rr_irq");
    rd_chk("rr_period", 7'h06, 16'd100);
    rd_chk("rr_high", 7'h04, 16'd25);
    repeat (35) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rr_dataout", dataout, 16'h0000);
    check("rr_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    pmode = 0;
    for (int i = 0; i < 5; i++)
      rd_chk({"rr_", rst_tab[i].name}, rst_tab[i].a, rst_tab[i].exp);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
